// File: rtl/proc_ctrl_sequencer.sv
// Instruction sequencer replaying decoded words onto the Processor control ports.
// Optional fetch gating by an external step input: define CTRL_SINGLE_STEP_EN.
module proc_ctrl_sequencer #(
   parameter int         ADDR_W  = 9,
   parameter int         DATA_W  = 32,
   parameter logic [1:0] ALU_ADD = 2'b00,
   parameter logic [1:0] ALU_MUL = 2'b01
) (
   input  logic              clk,
   input  logic              reset,
`ifdef CTRL_SINGLE_STEP_EN
   input  logic              step,
`endif
   input  logic              instr_valid,
   input  logic [31:0]       instr_data,
   output logic              instr_ready,
   output logic              reg_write_enable,
   output logic              mem_write_enable,
   output logic              mem_read_enable,
   output logic [1:0]        reg_address1,
   output logic [1:0]        reg_address2,
   output logic [1:0]        alu_op,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data_in,
   output logic              halted,
   output logic              illegal,
   output logic [15:0]       retired
);
   localparam logic [3:0] OP_NOP   = 4'd0;
   localparam logic [3:0] OP_WRMEM = 4'd1;
   localparam logic [3:0] OP_LOAD  = 4'd2;
   localparam logic [3:0] OP_ADD   = 4'd3;
   localparam logic [3:0] OP_MUL   = 4'd4;
   localparam logic [3:0] OP_STORE = 4'd5;
   localparam logic [3:0] OP_HALT  = 4'd15;

   typedef enum logic [2:0] {S_FETCH, S_EXT, S_E1, S_E2, S_HALT} state_t;

   state_t            state_q, state_d;
   logic              fetch_rdy, accept, fetch_acc;
   logic [3:0]        op_q, op_n;
   logic [1:0]        rd_q, rs_q, rd_n, rs_n;
   logic [8:0]        addr_q, addr_n;
   logic              rwe_d, mwe_d, mre_d;
   logic [1:0]        ra1_d, ra2_d, alu_d;
   logic [ADDR_W-1:0] maddr_d;
   logic [DATA_W-1:0] mdata_d;
   logic              unused_fields;

   function automatic logic is_legal(input logic [3:0] op);
      return op inside {OP_NOP, OP_WRMEM, OP_LOAD, OP_ADD, OP_MUL, OP_STORE, OP_HALT};
   endfunction

   function automatic logic is_two_cycle(input logic [3:0] op);
      return op inside {OP_LOAD, OP_ADD, OP_MUL};
   endfunction

`ifdef CTRL_SINGLE_STEP_EN
   logic step_q, step_pending;

   // A fresh step edge wins over the clear so a step arriving while fetching is not lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         step_q       <= 1'b0;
         step_pending <= 1'b0;
      end else begin
         step_q <= step;
         if (step && !step_q)
            step_pending <= 1'b1;
         else if (fetch_acc)
            step_pending <= 1'b0;
      end
   end

   assign fetch_rdy = step_pending;
`else
   assign fetch_rdy = 1'b1;
`endif

   assign instr_ready   = ((state_q == S_FETCH) && fetch_rdy) || (state_q == S_EXT);
   assign accept        = instr_valid && instr_ready;
   assign fetch_acc     = accept && (state_q == S_FETCH);
   assign unused_fields = ^instr_data[23:9];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH: begin
            if (accept) begin
               case (instr_data[31:28])
                  OP_WRMEM:                           state_d = S_EXT;
                  OP_LOAD, OP_ADD, OP_MUL, OP_STORE:  state_d = S_E1;
                  OP_HALT:                            state_d = S_HALT;
                  default:                            state_d = S_FETCH;
               endcase
            end
         end
         S_EXT:   if (accept) state_d = S_E1;
         S_E1:    state_d = is_two_cycle(op_q) ? S_E2 : S_FETCH;
         S_E2:    state_d = S_FETCH;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   // Instruction fields are plain data, captured only when a first word is taken.
   always_ff @(posedge clk) begin
      if (fetch_acc) begin
         op_q   <= instr_data[31:28];
         rd_q   <= instr_data[27:26];
         rs_q   <= instr_data[25:24];
         addr_q <= instr_data[8:0];
      end
   end

   always_comb begin
      if (state_q == S_FETCH) begin
         op_n   = instr_data[31:28];
         rd_n   = instr_data[27:26];
         rs_n   = instr_data[25:24];
         addr_n = instr_data[8:0];
      end else begin
         op_n   = op_q;
         rd_n   = rd_q;
         rs_n   = rs_q;
         addr_n = addr_q;
      end
   end

   // Next-cycle control values: enables pulse only in E1/E2, everything else holds.
   always_comb begin
      rwe_d   = 1'b0;
      mwe_d   = 1'b0;
      mre_d   = 1'b0;
      ra1_d   = reg_address1;
      ra2_d   = reg_address2;
      alu_d   = alu_op;
      maddr_d = mem_address;
      mdata_d = mem_data_in;
      if (state_q == S_EXT && accept)
         mdata_d = DATA_W'(instr_data);
      if (state_d == S_E1 || state_d == S_E2) begin
         case (op_n)
            OP_LOAD: begin
               mre_d = 1'b1;
               if (state_d == S_E1) maddr_d = ADDR_W'(addr_n);
               else begin
                  rwe_d = 1'b1;
                  ra1_d = rd_n;
               end
            end
            OP_ADD, OP_MUL: begin
               ra1_d = rd_n;
               ra2_d = rs_n;
               alu_d = (op_n == OP_ADD) ? ALU_ADD : ALU_MUL;
               rwe_d = (state_d == S_E2);
            end
            OP_STORE: begin
               mwe_d   = 1'b1;
               ra2_d   = rs_n;
               maddr_d = ADDR_W'(addr_n);
            end
            OP_WRMEM: begin
               mwe_d   = 1'b1;
               maddr_d = ADDR_W'(addr_n);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reg_write_enable <= 1'b0;
         mem_write_enable <= 1'b0;
         mem_read_enable  <= 1'b0;
         reg_address1     <= '0;
         reg_address2     <= '0;
         alu_op           <= '0;
         mem_address      <= '0;
         mem_data_in      <= '0;
         halted           <= 1'b0;
         illegal          <= 1'b0;
         retired          <= '0;
      end else begin
         reg_write_enable <= rwe_d;
         mem_write_enable <= mwe_d;
         mem_read_enable  <= mre_d;
         reg_address1     <= ra1_d;
         reg_address2     <= ra2_d;
         alu_op           <= alu_d;
         mem_address      <= maddr_d;
         mem_data_in      <= mdata_d;
         halted           <= (state_d == S_HALT);
         if (fetch_acc && !is_legal(instr_data[31:28]))
            illegal <= 1'b1;
         if ((fetch_acc && (instr_data[31:28] == OP_NOP || instr_data[31:28] == OP_HALT)) ||
             ((state_q == S_E1 || state_q == S_E2) && state_d == S_FETCH))
            retired <= retired + 16'd1;
      end
   end
endmodule

// File: tb/tb_proc_ctrl_sequencer.sv
// Randomized and directed bench for proc_ctrl_sequencer against a transaction-schedule model.
module tb_proc_ctrl_sequencer;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        instr_valid = 1'b0;
   logic [31:0] instr_data = '0;
   logic        instr_ready, reg_write_enable, mem_write_enable, mem_read_enable;
   logic [1:0]  reg_address1, reg_address2, alu_op;
   logic [8:0]  mem_address;
   logic [31:0] mem_data_in;
   logic        halted, illegal;
   logic [15:0] retired;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   proc_ctrl_sequencer dut (
      .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_data(instr_data),
      .instr_ready(instr_ready), .reg_write_enable(reg_write_enable),
      .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
      .reg_address1(reg_address1), .reg_address2(reg_address2), .alu_op(alu_op),
      .mem_address(mem_address), .mem_data_in(mem_data_in),
      .halted(halted), .illegal(illegal), .retired(retired)
   );

   // One entry per execute cycle an accepted instruction will show on the control ports.
   typedef struct {
      logic        rwe, mwe, mre;
      logic [1:0]  ra1, ra2, alu;
      logic [8:0]  maddr;
      logic [31:0] mdata;
      logic        last;
   } ent_t;

   ent_t        q[$];
   ent_t        held, cur;
   bit          m_halt, m_ill, m_ext, m_busy, m_acc;
   logic [15:0] m_ret;
   logic [8:0]  m_ext_addr;

   function automatic logic [31:0] enc(input int op, input int rd, input int rs, input int addr);
      return {op[3:0], rd[1:0], rs[1:0], 15'd0, addr[8:0]};
   endfunction

   function automatic ent_t base_ent();
      ent_t e = held;
      e.rwe = 1'b0; e.mwe = 1'b0; e.mre = 1'b0; e.last = 1'b0;
      return e;
   endfunction

   task automatic push(input ent_t e);
      q.push_back(e);
      held = e;
   endtask

   task automatic model_reset();
      q.delete();
      held = '{default: '0};
      cur  = held;
      m_halt = 0; m_ill = 0; m_ext = 0; m_busy = 0; m_acc = 0;
      m_ret = '0; m_ext_addr = '0;
   endtask

   task automatic model_edge(input logic v, input logic [31:0] d);
      logic [3:0] op = d[31:28];
      logic [1:0] rd = d[27:26];
      logic [1:0] rs = d[25:24];
      logic [8:0] a  = d[8:0];
      ent_t e;
      m_acc = v && !m_halt && !m_busy;
      if (cur.last) m_ret++;
      if (m_acc) begin
         if (m_ext) begin
            e = base_ent(); e.mwe = 1; e.maddr = m_ext_addr; e.mdata = d; e.last = 1; push(e);
            m_ext = 0;
         end else begin
            case (op)
               4'd0: m_ret++;
               4'd1: begin m_ext = 1; m_ext_addr = a; end
               4'd2: begin
                  e = base_ent(); e.mre = 1; e.maddr = a; push(e);
                  e.rwe = 1; e.ra1 = rd; e.last = 1; push(e);
               end
               4'd3, 4'd4: begin
                  e = base_ent(); e.ra1 = rd; e.ra2 = rs; e.alu = (op == 4'd3) ? 2'b00 : 2'b01; push(e);
                  e.rwe = 1; e.last = 1; push(e);
               end
               4'd5: begin
                  e = base_ent(); e.mwe = 1; e.ra2 = rs; e.maddr = a; e.last = 1; push(e);
               end
               4'd15: begin m_halt = 1; m_ret++; end
               default: m_ill = 1;
            endcase
         end
      end
      if (q.size() != 0) begin cur = q.pop_front(); m_busy = 1; end
      else begin cur = base_ent(); m_busy = 0; end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("instr_ready", instr_ready, !m_halt && !m_busy);
      chk("reg_write_enable", reg_write_enable, cur.rwe);
      chk("mem_write_enable", mem_write_enable, cur.mwe);
      chk("mem_read_enable", mem_read_enable, cur.mre);
      chk("reg_address1", reg_address1, cur.ra1);
      chk("reg_address2", reg_address2, cur.ra2);
      chk("alu_op", alu_op, cur.alu);
      chk("mem_address", mem_address, cur.maddr);
      chk("mem_data_in", mem_data_in, cur.mdata);
      chk("halted", halted, m_halt);
      chk("illegal", illegal, m_ill);
      chk("retired", retired, m_ret);
   endtask

   task automatic cyc(input logic v, input logic [31:0] d);
      instr_valid = v;
      instr_data  = d;
      @(posedge clk);
      model_edge(v, d);
      #1 check_all();
   endtask

   task automatic send(input logic [31:0] w);
      int n = 0;
      do begin
         cyc(1'b1, w);
         n++;
      end while (!m_acc && n < 20);
      if (!m_acc) begin
         checks++;
         errors++;
         $error("FAIL send_timeout word %0h not taken after %0d cycles", w, n);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, $urandom);
   endtask

   initial begin
      int nacc;
      logic [15:0] r0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 check_all();
      @(negedge clk) reset = 1'b0;

      send(enc(1, 0, 0, 9'h001)); send(32'h0000000A);
      send(enc(1, 0, 0, 9'h005)); send(32'h00000005);
      send(enc(1, 0, 0, 9'h00A)); send(32'h00000014);
      idle(2);
      chk("wrmem_retired", retired, 16'd3);
      chk("wrmem_last_data", mem_data_in, 32'h14);

      send(enc(2, 0, 0, 9'h001));
      chk("load_e1_mre", mem_read_enable, 1'b1);
      idle(3);
      send(enc(3, 0, 1, 0));
      chk("add_alu", alu_op, 2'b00);
      idle(1);
      send(enc(4, 2, 3, 0));
      chk("mul_alu", alu_op, 2'b01);
      idle(3);

      r0 = m_ret;
      nacc = 0;
      for (int i = 0; i < 24; i++) begin
         cyc((i % 2) == 0, enc(2, $urandom_range(0, 3), 0, $urandom_range(0, 511)));
         if (m_acc) nacc++;
      end
      idle(3);
      chk("toggle_retired", retired, r0 + 16'(nacc));

      for (int i = 0; i < 600; i++)
         cyc(($urandom % 4) != 0, {4'($urandom_range(0, 14)), 28'($urandom)});
      idle(4);

      send(enc(2, 1, 0, 9'h033));
      cyc(1'b0, 0);
      chk("e2_rwe", reg_write_enable, 1'b1);
      #2 reset = 1'b1;
      #1 model_reset();
      check_all();
      chk("rst_rwe", reg_write_enable, 1'b0);
      @(negedge clk) reset = 1'b0;
      send(enc(5, 0, 2, 9'h1F0));
      idle(2);
      chk("post_rst_retired", retired, 16'd1);

      send(enc(7, 0, 0, 0));
      send(enc(0, 0, 0, 0));
      send(enc(15, 0, 0, 0));
      for (int i = 0; i < 5; i++) cyc(1'b1, enc(2, 0, 0, 1));
      chk("halt_halted", halted, 1'b1);
      chk("halt_illegal", illegal, 1'b1);
      chk("halt_retired", retired, 16'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
